// File: rtl/fw_rule_sram_responder_pkg.sv
// Shared rule-table definitions: FSM codes, grant pointer and rule word layout.
// The packet filter imports the same package for slot positions.
package fw_rule_sram_responder_pkg;

    localparam int RULE_SLOT_W = 18;
    localparam int RULE_SLOTS  = 4;
    localparam int RULE_WORD_W = RULE_SLOT_W * RULE_SLOTS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } fsm_state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    // Slot k of a rule word occupies [lsb+17:lsb].
    function automatic int rule_slot_lsb(input int k);
        return k * RULE_SLOT_W;
    endfunction

endpackage

// File: rtl/fw_rule_sram_responder_mem.sv
// Single-port rule RAM, registered read, write-first on a same-cycle write.
module fw_rule_sram_responder_mem
    import fw_rule_sram_responder_pkg::*;
#(
    parameter int DATA_W = RULE_WORD_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fw_rule_sram_responder.sv
// Rule-table SRAM slave: latches rd/wr requests, arbitrates them, clears the RAM after reset
// and returns read data RD_LATENCY cycles after each read ack.
//   state   | meaning
//   ST_INIT | zeroing RAM one word per cycle, requests latched but not granted
//   ST_IDLE | serving requests, one grant per cycle
module fw_rule_sram_responder
    import fw_rule_sram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = RULE_WORD_W,
    parameter int MEM_DEPTH_BITS  = 8,
    parameter int RD_LATENCY      = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rd_0_req_i,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr_i,
    output logic                       rd_0_ack_o,
    output logic                       rd_0_vld_o,
    output logic [SRAM_DATA_WIDTH-1:0] rd_0_data_o,
    input  logic                       wr_0_req_i,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr_i,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_0_data_i,
    output logic                       wr_0_ack_o
);

    localparam int PIPE = RD_LATENCY - 1;

    fsm_state_e                 state_q, state_d;
    logic [MEM_DEPTH_BITS-1:0]  init_cnt_q, init_cnt_d;
    logic                       rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                       rd_ack_q, wr_ack_q;
    grant_e                     last_grant_q, last_grant_d;
    logic                       s1_vld_q, s1_oor_q;

    logic rd_new, wr_new, rd_want, wr_want, gnt_rd, gnt_wr;
    logic rd_in_range, wr_in_range;
    logic                       mem_en, mem_we;
    logic [MEM_DEPTH_BITS-1:0]  mem_addr;
    logic [SRAM_DATA_WIDTH-1:0] mem_wdata, mem_rdata, s1_data;

    // A request raised in its own ack cycle is absorbed, not re-captured.
    assign rd_new  = rd_0_req_i && !rd_pend_q && !rd_ack_q;
    assign wr_new  = wr_0_req_i && !wr_pend_q && !wr_ack_q;
    assign rd_want = rd_pend_q || rd_new;
    assign wr_want = wr_pend_q || wr_new;

    // Range check on the full address; truncation happens only at the RAM port.
    assign rd_in_range = (rd_addr_q[SRAM_ADDR_WIDTH-1:MEM_DEPTH_BITS] == '0);
    assign wr_in_range = (wr_addr_q[SRAM_ADDR_WIDTH-1:MEM_DEPTH_BITS] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q - 1'b1;
            if (init_cnt_q == '0) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_INIT: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = init_cnt_q;
            end
            ST_IDLE: begin
                if (rd_want && wr_want) begin
                    gnt_wr = (last_grant_q == GNT_RD);
                    gnt_rd = !gnt_wr;
                end else begin
                    gnt_rd = rd_want;
                    gnt_wr = wr_want;
                end
                // The RAM port belongs to whichever request is in its ack cycle.
                if (rd_ack_q) begin
                    mem_en   = 1'b1;
                    mem_addr = rd_addr_q[MEM_DEPTH_BITS-1:0];
                end else if (wr_ack_q && wr_in_range) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr_q[MEM_DEPTH_BITS-1:0];
                    mem_wdata = wr_data_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_pend_d    = rd_pend_q;
        wr_pend_d    = wr_pend_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (rd_new) begin
            rd_addr_d = rd_0_addr_i;
        end
        if (wr_new) begin
            wr_addr_d = wr_0_addr_i;
            wr_data_d = wr_0_data_i;
        end
        if (gnt_rd) begin
            rd_pend_d    = 1'b0;
            last_grant_d = GNT_RD;
        end else if (rd_new) begin
            rd_pend_d = 1'b1;
        end
        if (gnt_wr) begin
            wr_pend_d    = 1'b0;
            last_grant_d = GNT_WR;
        end else if (wr_new) begin
            wr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            last_grant_q <= GNT_RD;
            s1_vld_q     <= 1'b0;
            s1_oor_q     <= 1'b0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            wr_pend_q    <= wr_pend_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_ack_q     <= gnt_rd;
            wr_ack_q     <= gnt_wr;
            last_grant_q <= last_grant_d;
            s1_vld_q     <= rd_ack_q;
            s1_oor_q     <= !rd_in_range;
        end
    end

    fw_rule_sram_responder_mem #(
        .DATA_W (SRAM_DATA_WIDTH),
        .ADDR_W (MEM_DEPTH_BITS)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign s1_data = s1_oor_q ? '0 : mem_rdata;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            logic [SRAM_DATA_WIDTH-1:0] hold_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hold_q <= '0;
                end else if (s1_vld_q) begin
                    hold_q <= s1_data;
                end
            end
            assign rd_0_vld_o  = s1_vld_q;
            assign rd_0_data_o = s1_vld_q ? s1_data : hold_q;
        end else begin : g_latn
            // Each stage loads only when a valid word arrives, so the last stage holds between vlds.
            logic [PIPE-1:0]            vld_q;
            logic [SRAM_DATA_WIDTH-1:0] data_q [PIPE];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int i = 0; i < PIPE; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= s1_vld_q;
                    if (s1_vld_q) begin
                        data_q[0] <= s1_data;
                    end
                    for (int i = 1; i < PIPE; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end
            assign rd_0_vld_o  = vld_q[PIPE-1];
            assign rd_0_data_o = data_q[PIPE-1];
        end
    endgenerate

    assign rd_0_ack_o = rd_ack_q;
    assign wr_0_ack_o = wr_ack_q;

endmodule

// File: tb/tb_fw_rule_sram_responder.sv
// Directed bench for the rule-table SRAM responder: INIT, arbitration, merging, pipelining, range, reset.
module tb_fw_rule_sram_responder;

    localparam int AW = 19;
    localparam int DW = 72;

    localparam logic [DW-1:0] D1   = 72'h0_0050_0000_0000_0BB8;
    localparam logic [DW-1:0] D2   = 72'h1_2345_6789_ABCD_EF01;
    localparam logic [DW-1:0] D10  = 72'h5_5555_AAAA_5555_AAAA;
    localparam logic [DW-1:0] A0   = 72'hA_0000_0000_0000_00A0;
    localparam logic [DW-1:0] A1   = 72'hA_1111_1111_1111_11A1;
    localparam logic [DW-1:0] A2   = 72'hA_2222_2222_2222_22A2;
    localparam logic [DW-1:0] V255 = 72'hF_F00F_F00F_F00F_F0FF;
    localparam logic [DW-1:0] WBAD = 72'hD_EADB_EEFD_EADB_EEF0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack, rd_vld;
    logic [DW-1:0] rd_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fw_rule_sram_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd_0_req_i  (rd_req),
        .rd_0_addr_i (rd_addr),
        .rd_0_ack_o  (rd_ack),
        .rd_0_vld_o  (rd_vld),
        .rd_0_data_o (rd_data),
        .wr_0_req_i  (wr_req),
        .wr_0_addr_i (wr_addr),
        .wr_0_data_i (wr_data),
        .wr_0_ack_o  (wr_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-state write: acked on the first edge, then one spare cycle so the next request is not absorbed.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_req = 1'b0;
        tick();
    endtask

    // Idle-state read: ack on edge 1, vld on edge 3.
    task automatic do_read(input logic [AW-1:0] a, output logic got, output logic [DW-1:0] d);
        rd_req = 1'b1; rd_addr = a;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        got = rd_vld;
        d   = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (rd_ack !== 1'b0) begin fails++; $display("FAIL reset_rd_ack got %b want 0", rd_ack); end
        checks++; if (rd_vld !== 1'b0) begin fails++; $display("FAIL reset_rd_vld got %b want 0", rd_vld); end
        checks++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
        checks++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    endtask

    // Read raised with reset release: INIT takes edges 1..256, grant in the first IDLE cycle -> ack after edge 257.
    task automatic test_init_read();
        int ack_at = 0, vld_at = 0, acks = 0, wacks = 0;
        logic [DW-1:0] vdata = '1;
        rst_n = 1'b1; rd_req = 1'b1; rd_addr = 19'd5;
        for (int n = 1; n <= 270; n++) begin
            tick();
            rd_req = 1'b0;
            if (rd_ack) begin acks++; if (ack_at == 0) ack_at = n; end
            if (wr_ack) wacks++;
            if (rd_vld && vld_at == 0) begin vld_at = n; vdata = rd_data; end
        end
        checks++; if (ack_at != 257) begin fails++; $display("FAIL init_ack_edge got %0d want 257", ack_at); end
        checks++; if (acks != 1) begin fails++; $display("FAIL init_ack_count got %0d want 1", acks); end
        checks++; if (wacks != 0) begin fails++; $display("FAIL init_wr_ack_count got %0d want 0", wacks); end
        checks++; if (vld_at != 259) begin fails++; $display("FAIL init_vld_edge got %0d want 259", vld_at); end
        checks++; if (vdata !== '0) begin fails++; $display("FAIL init_rd_data got %h want 0", vdata); end
    endtask

    task automatic preload();
        do_write(19'd0, A0);
        do_write(19'd1, A1);
        do_write(19'd2, A2);
    endtask

    task automatic test_write_read();
        wr_req = 1'b1; wr_addr = 19'd3; wr_data = D1;
        tick();
        wr_req = 1'b0;
        checks++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin fails++; $display("FAIL wr_then_rd_wack got wr=%b rd=%b want wr=1 rd=0", wr_ack, rd_ack); end
        rd_req = 1'b1; rd_addr = 19'd3;
        tick();
        rd_req = 1'b0;
        checks++; if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin fails++; $display("FAIL wr_then_rd_rack got rd=%b wr=%b want rd=1 wr=0", rd_ack, wr_ack); end
        tick();
        checks++; if (rd_vld !== 1'b0) begin fails++; $display("FAIL wr_then_rd_early_vld got %b want 0", rd_vld); end
        tick();
        checks++; if (rd_vld !== 1'b1 || rd_data !== D1) begin fails++; $display("FAIL wr_then_rd_data got vld=%b %h want vld=1 %h", rd_vld, rd_data, D1); end
    endtask

    // last_grant is READ here, so the write wins and the read must return the new word.
    task automatic test_same_cycle();
        rd_req = 1'b1; rd_addr = 19'd3;
        wr_req = 1'b1; wr_addr = 19'd3; wr_data = D2;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        checks++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin fails++; $display("FAIL same_cycle_first got wr=%b rd=%b want wr=1 rd=0", wr_ack, rd_ack); end
        tick();
        checks++; if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin fails++; $display("FAIL same_cycle_second got rd=%b wr=%b want rd=1 wr=0", rd_ack, wr_ack); end
        tick(); tick();
        checks++; if (rd_vld !== 1'b1 || rd_data !== D2) begin fails++; $display("FAIL same_cycle_data got vld=%b %h want vld=1 %h", rd_vld, rd_data, D2); end
    endtask

    // Read level held while pending (write wins first) and through its ack cycle, address changing each cycle.
    task automatic test_held_req();
        int racks = 0, wacks = 0, vlds = 0, rack_at = -1;
        logic [DW-1:0] vdata = '1;
        wr_req = 1'b1; wr_addr = 19'd10; wr_data = D10;
        rd_req = 1'b1; rd_addr = 19'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (rd_ack) begin racks++; rack_at = k; end
            if (wr_ack) wacks++;
            if (rd_vld) begin vlds++; vdata = rd_data; end
            if (k == 0) begin wr_req = 1'b0; rd_addr = 19'd1; end
            if (k == 1) rd_addr = 19'd2;
            if (k == 2) rd_req = 1'b0;
        end
        checks++; if (racks != 1) begin fails++; $display("FAIL held_rd_acks got %0d want 1", racks); end
        checks++; if (rack_at != 1) begin fails++; $display("FAIL held_rd_ack_edge got %0d want 1", rack_at); end
        checks++; if (wacks != 1) begin fails++; $display("FAIL held_wr_acks got %0d want 1", wacks); end
        checks++; if (vlds != 1) begin fails++; $display("FAIL held_vlds got %0d want 1", vlds); end
        checks++; if (vdata !== A0) begin fails++; $display("FAIL held_data got %h want %h", vdata, A0); end
    endtask

    // Reads issued every other cycle: vld of one read coincides with the ack of the next.
    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4] = '{19'd1, 19'd2, 19'd3, 19'h400};
        logic [DW-1:0] exp_d [4] = '{A1, A2, D2, 72'h0};
        logic exp_ack, exp_vld;
        for (int k = 0; k < 10; k++) begin
            exp_ack = (k % 2 == 0) && (k <= 6);
            exp_vld = (k % 2 == 0) && (k >= 2) && (k <= 8);
            rd_req = exp_ack;
            if (exp_ack) rd_addr = addrs[k/2];
            tick();
            checks++; if (rd_ack !== exp_ack) begin fails++; $display("FAIL b2b_ack slot %0d got %b want %b", k, rd_ack, exp_ack); end
            checks++; if (rd_vld !== exp_vld) begin fails++; $display("FAIL b2b_vld slot %0d got %b want %b", k, rd_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (rd_data !== exp_d[(k-2)/2]) begin fails++; $display("FAIL b2b_data slot %0d got %h want %h", k, rd_data, exp_d[(k-2)/2]); end
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_range();
        logic got;
        logic [DW-1:0] d;
        do_write(19'd255, V255);
        do_write(19'h100, WBAD);
        do_write(19'h403, WBAD);
        do_read(19'd255, got, d);
        checks++; if (!got || d !== V255) begin fails++; $display("FAIL range_top_word got vld=%b %h want vld=1 %h", got, d, V255); end
        do_read(19'h100, got, d);
        checks++; if (!got || d !== '0) begin fails++; $display("FAIL range_oor_256 got vld=%b %h want vld=1 0", got, d); end
        do_read(19'd3, got, d);
        checks++; if (!got || d !== D2) begin fails++; $display("FAIL range_no_alias_wr got vld=%b %h want vld=1 %h", got, d, D2); end
        do_read(19'h400FF, got, d);
        checks++; if (!got || d !== '0) begin fails++; $display("FAIL range_oor_high got vld=%b %h want vld=1 0", got, d); end
    endtask

    task automatic test_reset_in_flight();
        int ack_at = 0, vld_at = 0, acks = 0;
        logic [DW-1:0] vdata = '1;
        rd_req = 1'b1; rd_addr = 19'd255;
        tick();
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1; rd_addr = 19'd3;
        tick();
        rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_ack !== 1'b0 || rd_vld !== 1'b0 || wr_ack !== 1'b0 || rd_data !== '0) begin
            fails++; $display("FAIL rst_async got ack=%b vld=%b wack=%b data=%h want all 0", rd_ack, rd_vld, wr_ack, rd_data);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (rd_ack !== 1'b0 || rd_vld !== 1'b0 || wr_ack !== 1'b0 || rd_data !== '0) begin
                fails++; $display("FAIL rst_hold cycle %0d got ack=%b vld=%b wack=%b data=%h want all 0", n, rd_ack, rd_vld, wr_ack, rd_data);
            end
        end
        rst_n = 1'b1; rd_req = 1'b1; rd_addr = 19'd3;
        for (int n = 1; n <= 262; n++) begin
            tick();
            rd_req = 1'b0;
            if (rd_ack) begin acks++; if (ack_at == 0) ack_at = n; end
            if (rd_vld && vld_at == 0) begin vld_at = n; vdata = rd_data; end
        end
        checks++; if (ack_at != 257 || acks != 1) begin fails++; $display("FAIL rerun_init_ack got edge=%0d count=%0d want edge=257 count=1", ack_at, acks); end
        checks++; if (vld_at != 259) begin fails++; $display("FAIL rerun_init_vld got %0d want 259", vld_at); end
        checks++; if (vdata !== '0) begin fails++; $display("FAIL rerun_init_cleared got %h want 0", vdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_read();
        preload();
        test_write_read();
        test_same_cycle();
        test_held_req();
        test_back_to_back();
        test_range();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
